// File: rtl/riscv_pkg.sv
// Shared fetch definitions: the fetch FSM state encoding and the default reset vector.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        HALT
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, stall hold, redirect with stale-data discard.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises sticky fetch_err_o and halts fetch.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic [31:0] instr_pc_o,
    output logic        fetch_err_o
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic [31:0]  redirect_tgt;
    logic         misalign;
    logic         discard;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_tgt = redirect_pc_i;
    assign misalign     = redirect_i && (redirect_pc_i[1:0] != 2'b00) && (state != HALT);
`else
    logic redirect_lsb_unused;
    assign redirect_lsb_unused = ^redirect_pc_i[1:0];
    assign redirect_tgt        = {redirect_pc_i[31:2], 2'b00};
    assign misalign            = 1'b0;
`endif

    assign pc_next = pc + INSTR_BYTES;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            imem_req_o    <= 1'b0;
            imem_addr_o   <= RESET_PC;
            instr_o       <= 32'h0;
            instr_valid_o <= 1'b0;
            instr_pc_o    <= 32'h0;
            fetch_err_o   <= 1'b0;
            discard       <= 1'b0;
        end else if (misalign) begin
            state         <= HALT;
            imem_req_o    <= 1'b0;
            instr_valid_o <= 1'b0;
            fetch_err_o   <= 1'b1;
            discard       <= 1'b0;
        end else if (redirect_i && (state != HALT)) begin
            pc            <= redirect_tgt;
            imem_addr_o   <= redirect_tgt;
            instr_valid_o <= 1'b0;
            // A request already accepted by memory must still be drained before refetching.
            if ((state == WAIT && !imem_rvalid_i) || (state == REQ && imem_gnt_i)) begin
                state      <= WAIT;
                imem_req_o <= 1'b0;
                discard    <= 1'b1;
            end else begin
                state      <= REQ;
                imem_req_o <= 1'b1;
                discard    <= 1'b0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    state       <= REQ;
                    imem_req_o  <= 1'b1;
                    imem_addr_o <= pc;
                end
                REQ: begin
                    instr_valid_o <= 1'b0;
                    if (imem_gnt_i) begin
                        state      <= WAIT;
                        imem_req_o <= 1'b0;
                    end
                end
                WAIT: begin
                    instr_valid_o <= 1'b0;
                    if (imem_rvalid_i) begin
                        if (discard) begin
                            discard     <= 1'b0;
                            state       <= REQ;
                            imem_req_o  <= 1'b1;
                            imem_addr_o <= pc;
                        end else begin
                            instr_o       <= imem_rdata_i;
                            instr_pc_o    <= pc;
                            instr_valid_o <= 1'b1;
                            pc            <= pc_next;
                            if (stall_i) begin
                                state <= HOLD;
                            end else begin
                                state       <= REQ;
                                imem_req_o  <= 1'b1;
                                imem_addr_o <= pc_next;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        state         <= REQ;
                        imem_req_o    <= 1'b1;
                        imem_addr_o   <= pc;
                        instr_valid_o <= 1'b0;
                    end
                end
                HALT: begin
                    imem_req_o    <= 1'b0;
                    instr_valid_o <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    imem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized memory timing, stalls and redirects,
// checked against an instruction-stream model (expected pc sequence and per-address memory words).
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic [31:0] instr_pc_o;
    logic        fetch_err_o;

    fetch_unit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .instr_o      (instr_o),
        .instr_valid_o(instr_valid_o),
        .instr_pc_o   (instr_pc_o),
        .fetch_err_o  (fetch_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;

    // Memory responder and stream-model state.
    bit          pending, rand_mem, use_fixed, stale_rv, halted;
    logic [31:0] pend_addr, fixed_word, exp_pc, last_pc;
    int          rv_wait, gnt_wait, gnt_delay, rv_delay, new_cnt;
    logic        prev_valid, prev_req;
    logic [31:0] prev_instr, prev_ipc, prev_addr;
    logic [31:0] gnt_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic respond();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        if (stale_rv) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hDEAD_BEEF;
        end else if (pending) begin
            if (rv_wait == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = use_fixed ? fixed_word : mem_word(pend_addr);
            end else begin
                rv_wait--;
            end
        end
        if (imem_req_o && !pending) begin
            if (gnt_wait == 0) imem_gnt_i = 1'b1;
            else gnt_wait--;
        end
    endtask

    // One clock: drive memory response at negedge, then sample and check at the next negedge.
    task automatic tick();
        logic        g, rv, r;
        logic [31:0] tgt, a;
        respond();
        g = imem_gnt_i; rv = imem_rvalid_i; r = redirect_i; tgt = redirect_pc_i; a = imem_addr_o;
        @(posedge clk_i);
        @(negedge clk_i);
        stale_rv   = 1'b0;
        redirect_i = 1'b0;
        if (rv) pending = 1'b0;
        if (g) begin
            pending   = 1'b1;
            pend_addr = a;
            gnt_q.push_back(a);
            rv_wait   = rand_mem ? int'($urandom_range(3, 0)) : rv_delay;
            gnt_wait  = rand_mem ? int'($urandom_range(3, 0)) : gnt_delay;
        end
        if (r && !halted) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (tgt[1:0] != 2'b00) halted = 1'b1;
            else exp_pc = tgt;
`else
            exp_pc = {tgt[31:2], 2'b00};
`endif
        end
        if (halted) begin
            chk("halt_req", 32'(imem_req_o), 32'd0);
            chk("halt_err", 32'(fetch_err_o), 32'd1);
            chk("halt_valid", 32'(instr_valid_o), 32'd0);
        end
        if (pending) chk("one_outstanding", 32'(imem_req_o), 32'd0);
        if (prev_req && !g && !r) begin
            chk("req_hold", 32'(imem_req_o), 32'd1);
            chk("addr_hold", imem_addr_o, prev_addr);
        end
        if (instr_valid_o && !prev_valid) begin
            chk("instr_pc", instr_pc_o, exp_pc);
            chk("instr_data", instr_o, use_fixed ? fixed_word : mem_word(exp_pc));
            last_pc = instr_pc_o;
            new_cnt++;
            exp_pc  = exp_pc + 32'd4;
        end else if (instr_valid_o && prev_valid) begin
            chk("hold_instr", instr_o, prev_instr);
            chk("hold_pc", instr_pc_o, prev_ipc);
            chk("hold_noreq", 32'(imem_req_o), 32'd0);
        end
        prev_valid = instr_valid_o; prev_instr = instr_o; prev_ipc = instr_pc_o;
        prev_req   = imem_req_o;    prev_addr  = imem_addr_o;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; redirect_i = 1'b0; stall_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_ipc", instr_pc_o, 32'h0);
        chk("rst_err", 32'(fetch_err_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        pending = 1'b0; halted = 1'b0; stale_rv = 1'b0; exp_pc = 32'h0;
        prev_valid = 1'b0; prev_req = 1'b0; prev_addr = 32'h0;
        gnt_wait = gnt_delay; rv_wait = 0;
    endtask

    task automatic run_until_new(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && new_cnt < target; i++) tick();
        chk(tag, 32'(new_cnt), 32'(target));
    endtask

    initial begin
        int base, idx, hi_cnt;
        rand_mem = 1'b0; use_fixed = 1'b0; fixed_word = 32'h0; new_cnt = 0; last_pc = 32'h0;
        gnt_delay = 0; rv_delay = 0;
        @(negedge clk_i);

        // Immediate grant/rvalid with a fixed read word.
        use_fixed = 1'b1; fixed_word = 32'h9300_5000;
        do_reset();
        gnt_q.delete(); new_cnt = 0;
        tick();
        chk("first_req", 32'(imem_req_o), 32'd1);
        chk("first_addr", imem_addr_o, 32'h0);
        tick();
        chk("wait_noreq", 32'(imem_req_o), 32'd0);
        tick();
        chk("lat_valid", 32'(instr_valid_o), 32'd1);
        chk("lat_pc", instr_pc_o, 32'h0);
        chk("lat_instr", instr_o, 32'h9300_5000);
        chk("second_addr", imem_addr_o, 32'h4);
        tick();
        chk("valid_pulse", 32'(instr_valid_o), 32'd0);
        run_until_new("seq_three", 3, 20);
        chk("gnt0", gnt_q[0], 32'h0);
        chk("gnt1", gnt_q[1], 32'h4);
        chk("gnt2", gnt_q[2], 32'h8);
        use_fixed = 1'b0;

        // Grant withheld for three cycles.
        gnt_delay = 3;
        do_reset();
        gnt_q.delete(); new_cnt = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dly_req", 32'(imem_req_o), 32'd1);
            chk("dly_addr", imem_addr_o, 32'h0);
        end
        tick();
        chk("dly_granted", 32'(imem_req_o), 32'd0);
        chk("dly_single", 32'(gnt_q.size()), 32'd1);
        gnt_delay = 0;

        // Stall held at rvalid and four further cycles.
        do_reset();
        tick(); tick();
        stall_i = 1'b1;
        hi_cnt = 0;
        tick();
        if (instr_valid_o) hi_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (instr_valid_o) hi_cnt++;
            chk("stall_noreq", 32'(imem_req_o), 32'd0);
        end
        chk("stall_instr", instr_o, mem_word(32'h0));
        stall_i = 1'b0;
        tick();
        chk("stall_valid_cycles", 32'(hi_cnt), 32'd5);
        chk("stall_drop", 32'(instr_valid_o), 32'd0);
        chk("stall_resume_req", 32'(imem_req_o), 32'd1);
        chk("stall_resume_addr", imem_addr_o, 32'h4);

        // Redirect while waiting on the read for 0x8.
        rv_delay = 2;
        for (int i = 0; i < 40 && !(pending && pend_addr == 32'h8); i++) tick();
        chk("reach_wait8", pend_addr, 32'h8);
        idx = gnt_q.size(); base = new_cnt;
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
        tick();
        run_until_new("redir_new", base + 1, 60);
        chk("redir_pc", last_pc, 32'h100);
        chk("redir_gnt", (gnt_q.size() > idx) ? gnt_q[idx] : 32'hFFFF_FFFF, 32'h100);
        rv_delay = 0;

        // Address wrap at the top of memory.
        base = new_cnt;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        run_until_new("wrap_a", base + 1, 40);
        chk("wrap_pc_a", last_pc, 32'hFFFF_FFFC);
        run_until_new("wrap_b", base + 2, 40);
        chk("wrap_pc_b", last_pc, 32'h0);

        // Reset mid-transaction, then stale rvalid in IDLE and REQ.
        gnt_delay = 2;
        tick(); tick();
        do_reset();
        stale_rv = 1'b1;
        tick();
        chk("stale_idle", 32'(instr_valid_o), 32'd0);
        stale_rv = 1'b1;
        tick();
        chk("stale_req", 32'(instr_valid_o), 32'd0);
        base = new_cnt;
        run_until_new("post_rst", base + 1, 40);
        chk("post_rst_pc", last_pc, 32'h0);
        gnt_delay = 0;

        // Misaligned redirect.
        tick();
        base = new_cnt;
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0102;
        tick();
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("trap_err", 32'(fetch_err_o), 32'd1);
        chk("trap_req", 32'(imem_req_o), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        tick();
        chk("trap_sticky", 32'(fetch_err_o), 32'd1);
        chk("trap_still_noreq", 32'(imem_req_o), 32'd0);
        do_reset();
        tick();
        chk("trap_cleared_req", 32'(imem_req_o), 32'd1);
`else
        run_until_new("align_new", base + 1, 40);
        chk("align_pc", last_pc, 32'h100);
        chk("align_noerr", 32'(fetch_err_o), 32'd0);
`endif

        // Randomized memory timing, stalls and redirects.
        rand_mem = 1'b1;
        do_reset();
        base = new_cnt;
        for (int i = 0; i < 3000; i++) begin
            stall_i = ($urandom_range(3, 0) == 0);
            if ($urandom_range(19, 0) == 0) begin
                redirect_i    = 1'b1;
                redirect_pc_i = $urandom & 32'hFFFF_FFFC;
            end
            tick();
        end
        stall_i = 1'b0;
        chk("rand_progress", 32'(new_cnt - base > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
